// File: rtl/smc_serial_sched.sv
// Serial MOSFET I_D/G_M scheduler: one compute unit, insertion-sorted result array, weighted reduce.
// Optional feature: define SMC_PIPE_EN to register the compute result ahead of the sort (+1 cycle latency).
module smc_serial_sched #(
    parameter int N_DEV = 6,
    parameter int VTH   = 1,
    parameter int VAL_W = 7,
    parameter int OUT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [2:0]       W,
    input  logic [2:0]       V_GS,
    input  logic [2:0]       V_DS,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_n
);
    localparam int         CNT_W = $clog2(N_DEV + 1);
    localparam logic [3:0] L_VTH = 4'(VTH);

    typedef enum logic [1:0] {IDLE, LOAD, PIPE, SUM} state_t;

    state_t                       r_state;
    logic [CNT_W-1:0]             r_count;
    logic [1:0]                   r_mode;
    logic                         r_ready;
    logic                         r_outValid;
    logic [OUT_W-1:0]             r_outN;
    logic [N_DEV-1:0][VAL_W-1:0]  r_s;

    logic                         w_beat;
    logic                         w_first;
    logic [1:0]                   w_mode;
    logic [3:0]                   w_vov;
    logic [15:0]                  w_num;
    logic [VAL_W-1:0]             w_val;
    logic                         w_insEn;
    logic                         w_insClear;
    logic [VAL_W-1:0]             w_insVal;
    logic [N_DEV-1:0][VAL_W-1:0]  w_base;
    logic [N_DEV-1:0][VAL_W-1:0]  w_ins;
    logic [OUT_W-1:0]             w_a, w_b, w_c, w_sum;

    assign w_beat  = in_valid && r_ready;
    assign w_first = (r_state == IDLE);
    assign w_mode  = w_first ? mode : r_mode;

    // Device model; cutoff clamps overdrive at zero so nothing wraps
    always_comb begin
        logic [15:0] vov16, vds16, w16;
        w_vov = ({1'b0, V_GS} > L_VTH) ? ({1'b0, V_GS} - L_VTH) : 4'd0;
        vov16 = 16'(w_vov);
        vds16 = 16'(V_DS);
        w16   = 16'(W);
        w_num = '0;
        if (w_vov > {1'b0, V_DS}) begin
            if (w_mode[0]) w_num = w16 * (16'd2 * vov16 * vds16 - vds16 * vds16);
            else           w_num = 16'd2 * w16 * vds16;
        end else begin
            if (w_mode[0]) w_num = w16 * vov16 * vov16;
            else           w_num = 16'd2 * w16 * vov16;
        end
        w_val = VAL_W'(w_num / 16'd3);
    end

`ifdef SMC_PIPE_EN
    logic [VAL_W-1:0] r_pval;
    logic             r_pvalid;
    logic             r_pfirst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pval   <= '0;
            r_pvalid <= 1'b0;
            r_pfirst <= 1'b0;
        end else begin
            r_pval   <= w_val;
            r_pvalid <= w_beat;
            r_pfirst <= w_beat && w_first;
        end
    end

    assign w_insEn    = r_pvalid;
    assign w_insClear = r_pfirst;
    assign w_insVal   = r_pval;
`else
    assign w_insEn    = w_beat;
    assign w_insClear = w_beat && w_first;
    assign w_insVal   = w_val;
`endif

    // Descending insert; a new value lands after existing equal entries, the tail slot drops out
    always_comb begin
        w_base = w_insClear ? '0 : r_s;
        w_ins  = w_base;
        w_ins[0] = (w_base[0] >= w_insVal) ? w_base[0] : w_insVal;
        for (int i = 1; i < N_DEV; i++) begin
            if (w_base[i] >= w_insVal)      w_ins[i] = w_base[i];
            else if (w_base[i-1] >= w_insVal) w_ins[i] = w_insVal;
            else                              w_ins[i] = w_base[i-1];
        end
    end

    always_comb begin
        w_a = r_mode[1] ? OUT_W'(r_s[0]) : OUT_W'(r_s[N_DEV-3]);
        w_b = r_mode[1] ? OUT_W'(r_s[1]) : OUT_W'(r_s[N_DEV-2]);
        w_c = r_mode[1] ? OUT_W'(r_s[2]) : OUT_W'(r_s[N_DEV-1]);
        w_sum = r_mode[0] ? (OUT_W'(3) * w_a + OUT_W'(4) * w_b + OUT_W'(5) * w_c)
                          : (w_a + w_b + w_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_mode     <= '0;
            r_ready    <= 1'b1;
            r_outValid <= 1'b0;
            r_outN     <= '0;
            r_s        <= '0;
        end else begin
            r_outValid <= 1'b0;
            if (w_insEn) r_s <= w_ins;
            case (r_state)
                IDLE: begin
                    if (w_beat) begin
                        r_mode  <= mode;
                        r_count <= CNT_W'(1);
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (w_beat) begin
                        if (r_count == CNT_W'(N_DEV - 1)) begin
                            r_count <= '0;
                            r_ready <= 1'b0;
`ifdef SMC_PIPE_EN
                            r_state <= PIPE;
`else
                            r_state <= SUM;
`endif
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                end
                PIPE: r_state <= SUM;
                SUM: begin
                    r_outN     <= w_sum;
                    r_outValid <= 1'b1;
                    r_ready    <= 1'b1;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_ready;
    assign out_valid = r_outValid;
    assign out_n     = r_outN;
endmodule
